rv32i_mc_ctrl: RTL and testbench

Multi-cycle control sequencer for the RV32I core. It takes the opcode and 4-bit func3 field from the instruction decoder, walks each instruction through fetch, decode, execute, memory and writeback, and drives the datapath controls and the instruction/data memory handshakes. It also keeps a retired-instruction counter.

---
 rtl/rv32i_mc_ctrl.sv | 202 ++++++++++++++++++++
 tb/tb_rv32i_mc_ctrl.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/rv32i_mc_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | rv32i_mc_ctrl : multi-cycle FETCH/DECODE/EXEC/MEM/WB control sequencer for |
// | RV32I. Optional macro RV32I_CTRL_TRAP_EN traps unlisted opcodes.           |
// | Revision 1.0                                                               |
// +----------------------------------------------------------------------------+
module rv32i_mc_ctrl #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [6:0]       opcode,
  input  logic [3:0]       func3,
  input  logic             br_taken,
  output logic             imem_req,
  input  logic             imem_ack,
  output logic             dmem_req,
  output logic             dmem_we,
  input  logic             dmem_ack,
  output logic             ir_we,
  output logic             pc_we,
  output logic [1:0]       pc_sel,
  output logic             alu_src_a,
  output logic             alu_src_b,
  output logic [3:0]       alu_op,
  output logic             reg_we,
  output logic [1:0]       wb_sel,
  output logic             instr_done,
  output logic [CNT_W-1:0] instret,
  output logic             illegal
);
  localparam logic [6:0] c_OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] c_OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] c_OPC_STORE  = 7'b0100011;
  localparam logic [6:0] c_OPC_OP     = 7'b0110011;
  localparam logic [6:0] c_OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] c_OPC_LUI    = 7'b0110111;
  localparam logic [6:0] c_OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] c_OPC_JAL    = 7'b1101111;
  localparam logic [6:0] c_OPC_JALR   = 7'b1100111;
  localparam logic [6:0] c_OPC_FENCE  = 7'b0001111;
  localparam logic [6:0] c_OPC_SYSTEM = 7'b1110011;

  typedef enum logic [2:0] {
    S_RESET  = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_TRAP   = 3'd6
  } state_t;

  function automatic logic f_is_legal(input logic [6:0] opc);
    case (opc)
      c_OPC_BRANCH, c_OPC_LOAD, c_OPC_STORE, c_OPC_OP, c_OPC_OPIMM, c_OPC_LUI,
      c_OPC_AUIPC, c_OPC_JAL, c_OPC_JALR, c_OPC_FENCE, c_OPC_SYSTEM: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic f_alu_a(input logic [6:0] opc);
    return (opc == c_OPC_BRANCH) || (opc == c_OPC_AUIPC) || (opc == c_OPC_JAL);
  endfunction

  function automatic logic f_alu_b(input logic [6:0] opc);
    case (opc)
      c_OPC_BRANCH, c_OPC_LOAD, c_OPC_STORE, c_OPC_OPIMM, c_OPC_AUIPC,
      c_OPC_JAL, c_OPC_JALR: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  // Only shift-right-immediate carries inst[30] into the ALU function for OPIMM.
  function automatic logic [3:0] f_alu_op(input logic [6:0] opc, input logic [3:0] f3);
    if (opc == c_OPC_OP) return f3;
    if (opc == c_OPC_OPIMM) return (f3[2:0] == 3'b101) ? f3 : {1'b0, f3[2:0]};
    return 4'b0000;
  endfunction

  function automatic logic f_wb_reg(input logic [6:0] opc);
    case (opc)
      c_OPC_OP, c_OPC_OPIMM, c_OPC_LUI, c_OPC_AUIPC, c_OPC_JAL, c_OPC_JALR,
      c_OPC_LOAD: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [1:0] f_wb_sel(input logic [6:0] opc);
    case (opc)
      c_OPC_LOAD:           return 2'd1;
      c_OPC_JAL, c_OPC_JALR: return 2'd2;
      c_OPC_LUI:            return 2'd3;
      default:              return 2'd0;
    endcase
  endfunction

  state_t           r_state;
  logic [6:0]       r_opc;
  logic             r_imem_req, r_dmem_req, r_dmem_we, r_pc_we, r_done;
  logic [1:0]       r_pc_sel, r_wb_sel;
  logic             r_alu_a, r_alu_b, r_reg_we;
  logic [3:0]       r_alu_op;
  logic [CNT_W-1:0] r_instret;
  logic             w_exec_br, w_st_done, w_trap;

`ifdef RV32I_CTRL_TRAP_EN
  logic r_illegal;
  assign w_trap = !f_is_legal(r_opc);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_illegal <= 1'b0;
    else if (r_state == S_EXEC && w_trap) r_illegal <= 1'b1;
  end
  assign illegal = r_illegal;
`else
  assign w_trap  = 1'b0;
  assign illegal = 1'b0;
`endif

  // Strobes qualified by same-cycle inputs (acks, branch result) stay combinational.
  assign w_exec_br  = (r_state == S_EXEC) && (r_opc == c_OPC_BRANCH);
  assign w_st_done  = (r_state == S_MEM) && r_dmem_we && dmem_ack;
  assign ir_we      = (r_state == S_FETCH) && imem_ack;
  assign pc_we      = r_pc_we | w_st_done;
  assign instr_done = r_done | w_st_done;
  assign pc_sel     = r_pc_sel | {1'b0, w_exec_br & br_taken};
  assign imem_req   = r_imem_req;
  assign dmem_req   = r_dmem_req;
  assign dmem_we    = r_dmem_we;
  assign alu_src_a  = r_alu_a;
  assign alu_src_b  = r_alu_b;
  assign alu_op     = r_alu_op;
  assign reg_we     = r_reg_we;
  assign wb_sel     = r_wb_sel;
  assign instret    = r_instret;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_RESET;   r_opc <= 7'd0;        r_instret <= '0;
      r_imem_req <= 1'b0;   r_dmem_req <= 1'b0;   r_dmem_we <= 1'b0;
      r_pc_we <= 1'b0;      r_pc_sel <= 2'd0;     r_done <= 1'b0;
      r_alu_a <= 1'b0;      r_alu_b <= 1'b0;      r_alu_op <= 4'd0;
      r_reg_we <= 1'b0;     r_wb_sel <= 2'd0;
    end else begin
      r_imem_req <= 1'b0;   r_dmem_req <= 1'b0;   r_dmem_we <= 1'b0;
      r_pc_we <= 1'b0;      r_pc_sel <= 2'd0;     r_done <= 1'b0;
      r_alu_a <= 1'b0;      r_alu_b <= 1'b0;      r_alu_op <= 4'd0;
      r_reg_we <= 1'b0;     r_wb_sel <= 2'd0;
      if (instr_done) r_instret <= r_instret + CNT_W'(1);
      case (r_state)
        S_RESET: begin
          r_state <= S_FETCH;  r_imem_req <= 1'b1;
        end
        S_FETCH: begin
          if (imem_ack) r_state <= S_DECODE;
          else r_imem_req <= 1'b1;
        end
        S_DECODE: begin
          r_state  <= S_EXEC;
          r_opc    <= opcode;
          r_alu_a  <= f_alu_a(opcode);
          r_alu_b  <= f_alu_b(opcode);
          r_alu_op <= f_alu_op(opcode, func3);
          r_pc_we  <= (opcode == c_OPC_BRANCH);
          r_done   <= (opcode == c_OPC_BRANCH);
        end
        S_EXEC: begin
          if (r_opc == c_OPC_BRANCH) begin
            r_state <= S_FETCH;  r_imem_req <= 1'b1;
          end else if (r_opc == c_OPC_LOAD || r_opc == c_OPC_STORE) begin
            r_state <= S_MEM;    r_dmem_req <= 1'b1;  r_dmem_we <= (r_opc == c_OPC_STORE);
          end else if (w_trap) begin
            r_state <= S_TRAP;
          end else begin
            r_state  <= S_WB;    r_pc_we <= 1'b1;      r_done <= 1'b1;
            r_alu_a  <= r_alu_a; r_alu_b <= r_alu_b;   r_alu_op <= r_alu_op;
            r_reg_we <= f_wb_reg(r_opc);
            r_wb_sel <= f_wb_sel(r_opc);
            r_pc_sel <= (r_opc == c_OPC_JAL || r_opc == c_OPC_JALR) ? 2'd1 : 2'd0;
          end
        end
        S_MEM: begin
          if (!dmem_ack) begin
            r_dmem_req <= 1'b1;  r_dmem_we <= r_dmem_we;
          end else if (r_dmem_we) begin
            r_state <= S_FETCH;  r_imem_req <= 1'b1;
          end else begin
            r_state  <= S_WB;    r_pc_we <= 1'b1;      r_done <= 1'b1;
            r_alu_a  <= f_alu_a(r_opc);  r_alu_b <= f_alu_b(r_opc);
            r_reg_we <= 1'b1;    r_wb_sel <= 2'd1;
          end
        end
        S_WB: begin
          r_state <= S_FETCH;  r_imem_req <= 1'b1;
        end
        S_TRAP:  r_state <= S_TRAP;
        default: r_state <= S_RESET;
      endcase
    end
  end
endmodule
`default_nettype wire

// File: tb/tb_rv32i_mc_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_rv32i_mc_ctrl : directed bench for rv32i_mc_ctrl, instruction-level     |
// | reference model checked every cycle plus literal spot checks.              |
// | Revision 1.0                                                               |
// +----------------------------------------------------------------------------+
module tb_rv32i_mc_ctrl;
  localparam int CNT_W = 32;
  localparam logic [6:0] c_BRANCH = 7'b1100011, c_LOAD = 7'b0000011, c_STORE = 7'b0100011;
  localparam logic [6:0] c_OP = 7'b0110011, c_OPIMM = 7'b0010011, c_LUI = 7'b0110111;
  localparam logic [6:0] c_AUIPC = 7'b0010111, c_JAL = 7'b1101111, c_JALR = 7'b1100111;
  localparam logic [6:0] c_FENCE = 7'b0001111, c_SYSTEM = 7'b1110011, c_BAD = 7'b1111111;
`ifdef RV32I_CTRL_TRAP_EN
  localparam bit c_TRAP = 1'b1;
`else
  localparam bit c_TRAP = 1'b0;
`endif

  typedef struct packed {
    logic       imem, dmem, dwe, irwe, pcwe;
    logic [1:0] pcsel;
    logic       a, b;
    logic [3:0] op;
    logic       regwe;
    logic [1:0] wbsel;
    logic       done, ill;
  } ov_t;

  logic clk = 1'b0, rst_n = 1'b0;
  logic [6:0] opcode;
  logic [3:0] func3;
  logic br_taken, imem_ack, dmem_ack;
  logic imem_req, dmem_req, dmem_we, ir_we, pc_we, alu_src_a, alu_src_b, reg_we;
  logic instr_done, illegal;
  logic [1:0] pc_sel, wb_sel;
  logic [3:0] alu_op;
  logic [CNT_W-1:0] instret;

  always #5 clk = ~clk;

  rv32i_mc_ctrl #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .func3(func3), .br_taken(br_taken),
    .imem_req(imem_req), .imem_ack(imem_ack), .dmem_req(dmem_req), .dmem_we(dmem_we),
    .dmem_ack(dmem_ack), .ir_we(ir_we), .pc_we(pc_we), .pc_sel(pc_sel),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op), .reg_we(reg_we),
    .wb_sel(wb_sel), .instr_done(instr_done), .instret(instret), .illegal(illegal)
  );

  ov_t w_dut;
  assign w_dut = {imem_req, dmem_req, dmem_we, ir_we, pc_we, pc_sel, alu_src_a, alu_src_b,
                  alu_op, reg_we, wb_sel, instr_done, illegal};

  int n_cmp = 0, n_bad = 0;
  logic chk_en = 1'b0, cnt_en = 1'b0;
  ov_t e_vec;
  logic [CNT_W-1:0] m_instret;
  int cyc_no = 0, first_irwe = 0, first_done = 0;
  int n_dreq = 0, n_dwe = 0, n_regwe = 0, n_ldwb = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Instruction-level reference tables
  function automatic logic m_listed(input logic [6:0] opc);
    return opc inside {c_BRANCH, c_LOAD, c_STORE, c_OP, c_OPIMM, c_LUI, c_AUIPC,
                       c_JAL, c_JALR, c_FENCE, c_SYSTEM};
  endfunction
  function automatic logic m_a(input logic [6:0] opc);
    return opc inside {c_BRANCH, c_AUIPC, c_JAL};
  endfunction
  function automatic logic m_b(input logic [6:0] opc);
    return opc inside {c_BRANCH, c_LOAD, c_STORE, c_OPIMM, c_AUIPC, c_JAL, c_JALR};
  endfunction
  function automatic logic [3:0] m_op(input logic [6:0] opc, input logic [3:0] f3);
    logic [3:0] r = 4'h0;
    if (opc == c_OP) r = f3;
    else if (opc == c_OPIMM) r = f3 & ((f3[2:0] == 3'b101) ? 4'hF : 4'h7);
    return r;
  endfunction
  function automatic logic m_rwe(input logic [6:0] opc);
    return opc inside {c_OP, c_OPIMM, c_LUI, c_AUIPC, c_JAL, c_JALR, c_LOAD};
  endfunction
  function automatic logic [1:0] m_wbs(input logic [6:0] opc);
    if (opc == c_LOAD) return 2'd1;
    if (opc == c_JAL || opc == c_JALR) return 2'd2;
    if (opc == c_LUI) return 2'd3;
    return 2'd0;
  endfunction

  always @(negedge clk) if (chk_en) begin
    check("outputs", 32'(w_dut), 32'(e_vec));
    check("instret", instret, m_instret);
  end

  always @(negedge clk) if (rst_n) begin
    if (first_irwe == 0 && ir_we) first_irwe = cyc_no;
    if (first_done == 0 && instr_done) first_done = cyc_no;
    if (cnt_en) begin
      if (dmem_req) n_dreq++;
      if (dmem_we) n_dwe++;
      if (reg_we) n_regwe++;
      if (reg_we && wb_sel == 2'd1) n_ldwb++;
    end
  end

  task automatic step();
    @(posedge clk); #1; cyc_no++;
  endtask

  // Drives one instruction from FETCH to retirement and sets the expected outputs per cycle.
  task automatic do_instr(input logic [6:0] opc, input logic [3:0] f3, input logic bt,
                          input int iw, input int dw, input int lit_alu, input int lit_pcsel);
    logic a, b, st;
    logic [3:0] op;
    a = m_a(opc); b = m_b(opc); op = m_op(opc, f3); st = (opc == c_STORE);
    opcode = opc; func3 = f3; br_taken = 1'b0;
    for (int k = 0; k <= iw; k++) begin
      imem_ack = (k == iw);
      e_vec = '0; e_vec.imem = 1'b1; e_vec.irwe = (k == iw);
      step();
    end
    imem_ack = 1'b0;
    e_vec = '0;
    step();
    e_vec = '0; e_vec.a = a; e_vec.b = b; e_vec.op = op;
    if (opc == c_BRANCH) begin
      br_taken = bt;
      e_vec.pcwe = 1'b1; e_vec.pcsel = {1'b0, bt}; e_vec.done = 1'b1;
      #1;
      if (lit_pcsel >= 0) check("lit_pc_sel", 32'(pc_sel), 32'(lit_pcsel));
      step();
      br_taken = 1'b0; m_instret++;
      return;
    end
    if (lit_alu >= 0) check("lit_alu_op", 32'(alu_op), 32'(lit_alu));
    step();
    if (opc == c_LOAD || opc == c_STORE) begin
      for (int k = 0; k <= dw; k++) begin
        dmem_ack = (k == dw);
        e_vec = '0; e_vec.dmem = 1'b1; e_vec.dwe = st;
        e_vec.pcwe = st && (k == dw); e_vec.done = st && (k == dw);
        step();
      end
      dmem_ack = 1'b0;
      if (st) begin m_instret++; return; end
    end else if (c_TRAP && !m_listed(opc)) begin
      return;
    end
    e_vec = '0; e_vec.a = a; e_vec.b = b; e_vec.op = op;
    e_vec.pcwe = 1'b1; e_vec.done = 1'b1; e_vec.regwe = m_rwe(opc); e_vec.wbsel = m_wbs(opc);
    e_vec.pcsel = (opc == c_JAL || opc == c_JALR) ? 2'd1 : 2'd0;
    step();
    m_instret++;
  endtask

  task automatic release_reset();
    @(posedge clk); #1;
    rst_n = 1'b1; m_instret = '0; e_vec = '0; chk_en = 1'b1;
    step();
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: simulation did not finish, n_cmp=%0d", n_cmp);
    $fatal(1);
  end

  initial begin
    opcode = 7'd0; func3 = 4'd0; br_taken = 1'b0; imem_ack = 1'b0; dmem_ack = 1'b0;
    m_instret = '0; e_vec = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_outputs", 32'(w_dut), 32'd0);
    check("reset_instret", instret, 32'd0);
    rst_n = 1'b1; cyc_no = 1; chk_en = 1'b1;
    step();

    do_instr(c_OP, 4'b0000, 1'b0, 0, 0, 0, -1);
    check("first_ir_we_cycle", 32'(first_irwe), 32'd2);
    check("first_done_cycle", 32'(first_done), 32'd5);
    check("instret_after_add", instret, 32'd1);

    do_instr(c_OP,    4'b1000, 1'b0, 0, 0, 8, -1);
    do_instr(c_OPIMM, 4'b1000, 1'b0, 0, 0, 0, -1);
    do_instr(c_OPIMM, 4'b1101, 1'b0, 1, 0, 13, -1);
    do_instr(c_LUI,   4'b0000, 1'b0, 0, 0, 0, -1);
    do_instr(c_AUIPC, 4'b0000, 1'b0, 0, 0, 0, -1);
    do_instr(c_JAL,   4'b0000, 1'b0, 0, 0, 0, -1);
    do_instr(c_JALR,  4'b0000, 1'b0, 2, 0, 0, -1);

    n_dreq = 0; n_dwe = 0; n_regwe = 0; n_ldwb = 0; cnt_en = 1'b1;
    do_instr(c_LOAD, 4'b0010, 1'b0, 0, 3, 0, -1);
    cnt_en = 1'b0;
    check("load_dmem_req_cycles", 32'(n_dreq), 32'd4);
    check("load_dmem_we_cycles", 32'(n_dwe), 32'd0);
    check("load_wb_sel1", 32'(n_ldwb), 32'd1);

    n_dreq = 0; n_dwe = 0; n_regwe = 0; cnt_en = 1'b1;
    do_instr(c_STORE, 4'b0010, 1'b0, 0, 2, 0, -1);
    cnt_en = 1'b0;
    check("store_dmem_req_cycles", 32'(n_dreq), 32'd3);
    check("store_dmem_we_cycles", 32'(n_dwe), 32'd3);
    check("store_reg_we_cycles", 32'(n_regwe), 32'd0);

    do_instr(c_BRANCH, 4'b0000, 1'b1, 0, 0, -1, 1);
    do_instr(c_BRANCH, 4'b0001, 1'b0, 0, 0, -1, 0);
    do_instr(c_FENCE,  4'b0000, 1'b0, 0, 0, 0, -1);
    do_instr(c_SYSTEM, 4'b0000, 1'b0, 0, 0, 0, -1);
    do_instr(c_BAD,    4'b0000, 1'b0, 0, 0, 0, -1);
`ifdef RV32I_CTRL_TRAP_EN
    for (int k = 0; k < 4; k++) begin
      e_vec = '0; e_vec.ill = 1'b1;
      step();
    end
    check("trap_illegal", 32'(illegal), 32'd1);
    check("trap_no_fetch", 32'(imem_req), 32'd0);
    check("trap_instret", instret, 32'd14);
    chk_en = 1'b0; rst_n = 1'b0;
    #1;
    check("trap_reset_illegal", 32'(illegal), 32'd0);
    release_reset();
    do_instr(c_OP, 4'b0000, 1'b0, 0, 0, 0, -1);
`else
    check("nop_instret", instret, 32'd15);
`endif

    // Abort a load while it waits for dmem_ack
    opcode = c_LOAD; func3 = 4'b0010;
    imem_ack = 1'b1; e_vec = '0; e_vec.imem = 1'b1; e_vec.irwe = 1'b1;
    step();
    imem_ack = 1'b0; e_vec = '0;
    step();
    e_vec = '0; e_vec.b = 1'b1;
    step();
    e_vec = '0; e_vec.dmem = 1'b1;
    step();
    step();
    #2;
    chk_en = 1'b0; rst_n = 1'b0;
    #1;
    check("async_dmem_req", 32'(dmem_req), 32'd0);
    check("async_instret", instret, 32'd0);
    check("async_outputs", 32'(w_dut), 32'd0);
    release_reset();
    do_instr(c_OP, 4'b0111, 1'b0, 0, 0, 7, -1);
    check("instret_after_reset", instret, 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
`default_nettype wire
